// File: rtl/t20_sdram_ctrl.sv
// Single-word SDRAM controller for the GW2AR-18 embedded 64 Mbit x32 SDRAM.
// Runs power-up init and auto-refresh, and serves one read/write per request.
module t20_sdram_ctrl #(
  parameter int unsigned INIT_CYCLES  = 25000,
  parameter int unsigned REF_INTERVAL = 975,
  parameter int unsigned CAS_LAT      = 2,
  parameter int unsigned T_RP         = 3,
  parameter int unsigned T_RCD        = 3,
  parameter int unsigned T_RC         = 9,
  parameter int unsigned T_WR         = 2,
  parameter int unsigned T_MRD        = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lock_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [20:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wmask_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        ready_o,
  output logic        sdram_cke_o,
  output logic        sdram_cs_n_o,
  output logic        sdram_ras_n_o,
  output logic        sdram_cas_n_o,
  output logic        sdram_we_n_o,
  output logic [1:0]  sdram_ba_o,
  output logic [10:0] sdram_a_o,
  output logic [3:0]  sdram_dqm_o,
  output logic [31:0] dq_o,
  output logic        dq_oe_o,
  input  logic [31:0] dq_i
);

  localparam int unsigned RdEndI = (T_RC > T_RCD + CAS_LAT + 2) ? T_RC : T_RCD + CAS_LAT + 2;
  localparam int unsigned WrEndI = (T_RC > T_RCD + 1 + T_WR + T_RP) ? T_RC : T_RCD + 1 + T_WR + T_RP;

  localparam logic [15:0] InitCnt = 16'(INIT_CYCLES);
  localparam logic [15:0] RefLast = 16'(REF_INTERVAL - 1);
  localparam logic [15:0] Trp     = 16'(T_RP);
  localparam logic [15:0] Trc     = 16'(T_RC);
  localparam logic [15:0] RcLast  = 16'(T_RC - 1);
  localparam logic [15:0] Tmrd    = 16'(T_MRD);
  localparam logic [15:0] Trcd    = 16'(T_RCD);
  localparam logic [15:0] RdData  = 16'(T_RCD + CAS_LAT + 1);
  localparam logic [15:0] RdLast  = 16'(RdEndI - 1);
  localparam logic [15:0] WrAck   = 16'(T_RCD + 1);
  localparam logic [15:0] WrLast  = 16'(WrEndI - 1);
  localparam logic [10:0] ModeReg = {4'b0000, 3'(CAS_LAT), 1'b0, 3'b000};

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CmdNop = 4'b1111;
  localparam logic [3:0] CmdAct = 4'b0011;
  localparam logic [3:0] CmdRd  = 4'b0101;
  localparam logic [3:0] CmdWr  = 4'b0100;
  localparam logic [3:0] CmdPre = 4'b0010;
  localparam logic [3:0] CmdRef = 4'b0001;
  localparam logic [3:0] CmdMrs = 4'b0000;

  typedef enum logic [3:0] {
    StWaitLock, StInitWait, StInitPre, StInitRef1, StInitRef2,
    StInitMrs, StIdle, StRefresh, StRead, StWrite
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, ref_cnt_q, ref_cnt_d;
  logic        ref_pend_q, ref_pend_d, cke_q, cke_d, dq_oe_q, dq_oe_d;
  logic        ack_q, ack_d, ready_q, ready_d;
  logic [3:0]  cmd_q, cmd_d, dqm_q, dqm_d;
  logic [1:0]  ba_q, ba_d;
  logic [10:0] a_q, a_d;
  logic [31:0] dq_q, dq_d, rdata_q, rdata_d;

  // cnt_q holds the index of the cycle whose pin values are being computed.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    ref_cnt_d  = ref_cnt_q + 16'd1;
    ref_pend_d = ref_pend_q;
    cke_d      = cke_q;
    cmd_d      = CmdNop;
    ba_d       = 2'd0;
    a_d        = 11'd0;
    dqm_d      = 4'hF;
    dq_d       = 32'd0;
    dq_oe_d    = 1'b0;
    rdata_d    = rdata_q;
    ack_d      = 1'b0;
    ready_d    = ready_q;

    case (state_q)
      StWaitLock: if (lock_i) begin
        cke_d   = 1'b1;
        state_d = StInitWait;
        cnt_d   = 16'd1;
      end
      StInitWait: if (cnt_q == InitCnt) begin
        cmd_d   = CmdPre;
        a_d     = 11'h400;
        state_d = StInitPre;
        cnt_d   = 16'd1;
      end
      StInitPre: if (cnt_q == Trp) begin
        cmd_d   = CmdRef;
        state_d = StInitRef1;
        cnt_d   = 16'd1;
      end
      StInitRef1: if (cnt_q == Trc) begin
        cmd_d   = CmdRef;
        state_d = StInitRef2;
        cnt_d   = 16'd1;
      end
      StInitRef2: if (cnt_q == Trc) begin
        cmd_d   = CmdMrs;
        a_d     = ModeReg;
        state_d = StInitMrs;
        cnt_d   = 16'd1;
      end
      StInitMrs: if (cnt_q == Tmrd) begin
        ready_d = 1'b1;
        state_d = StIdle;
      end
      StIdle: begin
        cnt_d = 16'd1;
        if (ref_pend_q) begin
          cmd_d      = CmdRef;
          ref_pend_d = 1'b0;
          state_d    = StRefresh;
        end else if (req_i) begin
          cmd_d   = CmdAct;
          ba_d    = addr_i[20:19];
          a_d     = addr_i[18:8];
          state_d = we_i ? StWrite : StRead;
        end
      end
      StRefresh: if (cnt_q == RcLast) state_d = StIdle;
      StRead: begin
        if (cnt_q == Trcd) begin
          cmd_d = CmdRd;
          ba_d  = addr_i[20:19];
          a_d   = {3'b100, addr_i[7:0]};
          dqm_d = 4'h0;
        end
        if (cnt_q == RdData) begin
          rdata_d = dq_i;
          ack_d   = 1'b1;
        end
        if (cnt_q == RdLast) state_d = StIdle;
      end
      StWrite: begin
        if (cnt_q == Trcd) begin
          cmd_d   = CmdWr;
          ba_d    = addr_i[20:19];
          a_d     = {3'b100, addr_i[7:0]};
          dqm_d   = ~wmask_i;
          dq_d    = wdata_i;
          dq_oe_d = 1'b1;
        end
        if (cnt_q == WrAck) ack_d = 1'b1;
        if (cnt_q == WrLast) state_d = StIdle;
      end
      default: state_d = StWaitLock;
    endcase

    if (!ready_q) begin
      ref_cnt_d = 16'd0;
    end else if (ref_cnt_q == RefLast) begin
      ref_cnt_d  = 16'd0;
      ref_pend_d = 1'b1;
    end

    // Losing PLL lock abandons everything, including an in-flight request.
    if (!lock_i) begin
      state_d    = StWaitLock;
      cnt_d      = 16'd0;
      ref_cnt_d  = 16'd0;
      ref_pend_d = 1'b0;
      cke_d      = 1'b0;
      cmd_d      = CmdNop;
      ba_d       = 2'd0;
      a_d        = 11'd0;
      dqm_d      = 4'hF;
      dq_d       = 32'd0;
      dq_oe_d    = 1'b0;
      ack_d      = 1'b0;
      ready_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StWaitLock;
      cnt_q      <= 16'd0;
      ref_cnt_q  <= 16'd0;
      ref_pend_q <= 1'b0;
      cke_q      <= 1'b0;
      cmd_q      <= CmdNop;
      ba_q       <= 2'd0;
      a_q        <= 11'd0;
      dqm_q      <= 4'hF;
      dq_q       <= 32'd0;
      dq_oe_q    <= 1'b0;
      rdata_q    <= 32'd0;
      ack_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      cke_q      <= cke_d;
      cmd_q      <= cmd_d;
      ba_q       <= ba_d;
      a_q        <= a_d;
      dqm_q      <= dqm_d;
      dq_q       <= dq_d;
      dq_oe_q    <= dq_oe_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      ready_q    <= ready_d;
    end
  end

  assign {sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o} = cmd_q;
  assign sdram_cke_o = cke_q;
  assign sdram_ba_o  = ba_q;
  assign sdram_a_o   = a_q;
  assign sdram_dqm_o = dqm_q;
  assign dq_o        = dq_q;
  assign dq_oe_o     = dq_oe_q;
  assign rdata_o     = rdata_q;
  assign ack_o       = ack_q;
  assign ready_o     = ready_q;

endmodule

// File: tb/tb_t20_sdram_ctrl.sv
// Directed bench for t20_sdram_ctrl: init sequence, write, read, refresh
// arbitration, lock loss and asynchronous reset.
module tb_t20_sdram_ctrl;

  localparam logic [3:0] NOP = 4'b1111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] MRS = 4'b0000;

  logic        clk = 1'b0;
  logic        reset_n, lock, req, we;
  logic [20:0] addr;
  logic [31:0] wdata, rdata, dq_o, dq_i;
  logic [3:0]  wmask, dqm;
  logic        ack, ready, cke, cs_n, ras_n, cas_n, we_n, dq_oe;
  logic [1:0]  ba;
  logic [10:0] a;
  logic [3:0]  cmd;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int ready_cyc, ref1_cyc, n, quiet_errs;

  assign cmd = {cs_n, ras_n, cas_n, we_n};

  t20_sdram_ctrl #(
    .INIT_CYCLES (10),
    .REF_INTERVAL(50)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (reset_n),
    .lock_i       (lock),
    .req_i        (req),
    .we_i         (we),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .wmask_i      (wmask),
    .rdata_o      (rdata),
    .ack_o        (ack),
    .ready_o      (ready),
    .sdram_cke_o  (cke),
    .sdram_cs_n_o (cs_n),
    .sdram_ras_n_o(ras_n),
    .sdram_cas_n_o(cas_n),
    .sdram_we_n_o (we_n),
    .sdram_ba_o   (ba),
    .sdram_a_o    (a),
    .sdram_dqm_o  (dqm),
    .dq_o         (dq_o),
    .dq_oe_o      (dq_oe),
    .dq_i         (dq_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Cycles until cmd appears (-1 if it never does within the budget).
  task automatic wait_cmd(input logic [3:0] c, output int cnt);
    cnt = -1;
    for (int i = 1; i <= 120; i++) begin
      tick();
      if (cmd === c) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic wait_ready(output int cnt);
    cnt = -1;
    for (int i = 1; i <= 120; i++) begin
      tick();
      if (ready === 1'b1) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic init_seq();
    int nops;
    int m;
    lock = 1'b1;
    tick();
    chk("cke_on", 32'(cke), 32'd1);
    chk("first_nop", 32'(cmd), 32'(NOP));
    nops = 0;
    for (int i = 0; i < 100 && cmd === NOP; i++) begin
      nops++;
      tick();
    end
    chk("init_nops", nops, 10);
    chk("pre_cmd", 32'(cmd), 32'(PRE));
    chk("pre_a10", 32'(a[10]), 32'd1);
    wait_cmd(REF, m);
    chk("ref1_dly", m, 3);
    wait_cmd(REF, m);
    chk("ref2_dly", m, 9);
    wait_cmd(MRS, m);
    chk("mrs_dly", m, 9);
    chk("mrs_a", 32'(a), 32'h020);
    chk("mrs_ba", 32'(ba), 32'd0);
    wait_ready(m);
    chk("ready_dly", m, 2);
    ready_cyc = cyc;
  endtask

  initial begin
    reset_n = 1'b0;
    lock    = 1'b0;
    req     = 1'b0;
    we      = 1'b0;
    addr    = '0;
    wdata   = '0;
    wmask   = '0;
    dq_i    = '0;
    repeat (3) tick();
    chk("rst_cke", 32'(cke), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'(NOP));
    chk("rst_dqm", 32'(dqm), 32'hF);
    chk("rst_oe", 32'(dq_oe), 32'd0);
    chk("rst_dq", dq_o, 32'd0);
    chk("rst_a", 32'(a), 32'd0);
    chk("rst_ba", 32'(ba), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);

    reset_n = 1'b1;
    repeat (20) tick();
    chk("nolock_cke", 32'(cke), 32'd0);
    chk("nolock_cmd", 32'(cmd), 32'(NOP));
    init_seq();

    // Masked write
    req = 1'b1; we = 1'b1; addr = 21'h1A5C3F; wdata = 32'hDEADBEEF; wmask = 4'b0101;
    wait_cmd(ACT, n);
    chk("wr_act_dly", n, 1);
    chk("wr_act_ba", 32'(ba), 32'd3);
    chk("wr_act_row", 32'(a), 32'h25C);
    chk("wr_act_oe", 32'(dq_oe), 32'd0);
    wait_cmd(WR, n);
    chk("wr_cmd_dly", n, 3);
    chk("wr_a", 32'(a), 32'h43F);
    chk("wr_dqm", 32'(dqm), 32'hA);
    chk("wr_oe", 32'(dq_oe), 32'd1);
    chk("wr_dq", dq_o, 32'hDEADBEEF);
    chk("wr_ack_early", 32'(ack), 32'd0);
    tick();
    chk("wr_ack", 32'(ack), 32'd1);
    chk("wr_oe_off", 32'(dq_oe), 32'd0);
    req = 1'b0;
    tick();
    chk("wr_ack_once", 32'(ack), 32'd0);

    // Read of the same word; model drives dq_i only in the CAS-2 data cycle
    req = 1'b1; we = 1'b0;
    wait_cmd(ACT, n);
    chk("rd_act_dly", n, 4);
    wait_cmd(RD, n);
    chk("rd_cmd_dly", n, 3);
    chk("rd_a", 32'(a), 32'h43F);
    chk("rd_dqm", 32'(dqm), 32'h0);
    tick();
    tick();
    dq_i = 32'h00AD00EF;
    chk("rd_ack_early", 32'(ack), 32'd0);
    tick();
    dq_i = 32'd0;
    chk("rd_ack", 32'(ack), 32'd1);
    chk("rd_data", rdata, 32'h00AD00EF);
    req = 1'b0;
    tick();
    chk("rd_ack_once", 32'(ack), 32'd0);

    // Request held across refresh expiry: refresh wins, ack delayed
    while (cyc < ready_cyc + 50) tick();
    req = 1'b1; we = 1'b1; addr = 21'h000105; wdata = 32'h12345678; wmask = 4'hF;
    wait_cmd(REF, n);
    chk("ref_first", n, 1);
    ref1_cyc = cyc;
    chk("ref_no_ack", 32'(ack), 32'd0);
    wait_cmd(ACT, n);
    chk("ref_act_dly", n, 9);
    wait_cmd(WR, n);
    chk("wr2_dly", n, 3);
    chk("wr2_a", 32'(a), 32'h405);
    chk("wr2_dqm", 32'(dqm), 32'h0);
    chk("wr2_dq", dq_o, 32'h12345678);
    tick();
    chk("wr2_ack", 32'(ack), 32'd1);
    req = 1'b0;
    wait_cmd(REF, n);
    chk("ref_period", cyc - ref1_cyc, 50);

    // Lock loss between ACTIVATE and READ
    req = 1'b1; we = 1'b0; addr = 21'h0A1234;
    wait_cmd(ACT, n);
    chk("ll_act_dly", n, 9);
    lock = 1'b0;
    tick();
    chk("ll_cke", 32'(cke), 32'd0);
    chk("ll_cmd", 32'(cmd), 32'(NOP));
    chk("ll_ready", 32'(ready), 32'd0);
    chk("ll_oe", 32'(dq_oe), 32'd0);
    quiet_errs = 0;
    repeat (6) begin
      tick();
      if (ack !== 1'b0 || cmd !== NOP) quiet_errs++;
    end
    chk("ll_quiet", quiet_errs, 0);
    req = 1'b0;
    init_seq();
    wait_cmd(REF, n);
    chk("relock_ref", n, 51);

    // Asynchronous reset during the WRITE command cycle
    req = 1'b1; we = 1'b1; addr = 21'h1A5C3F; wdata = 32'hCAFEF00D; wmask = 4'b0011;
    wait_cmd(ACT, n);
    chk("rw_act_dly", n, 9);
    wait_cmd(WR, n);
    chk("rw_wr_dly", n, 3);
    chk("rw_oe_pre", 32'(dq_oe), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rw_oe", 32'(dq_oe), 32'd0);
    chk("rw_dqm", 32'(dqm), 32'hF);
    chk("rw_cke", 32'(cke), 32'd0);
    chk("rw_cmd", 32'(cmd), 32'(NOP));
    chk("rw_ack", 32'(ack), 32'd0);
    req = 1'b0;
    tick();
    tick();
    chk("rw_ack_later", 32'(ack), 32'd0);
    chk("rw_ready", 32'(ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
